// File: rtl/button_event_gen_if.sv
// Event-side bundle of button_event_gen: key level in, one-deep valid/ready
// event stream and status flags out.
interface button_event_gen_if;
  logic       level;
  logic       ev_valid;
  logic [1:0] ev_code;
  logic       ev_ready;
  logic       pressed;
  logic       long_hold;
  logic       overflow;

  modport master (
    input  level, ev_ready,
    output ev_valid, ev_code, pressed, long_hold, overflow
  );

  modport slave (
    output level, ev_ready,
    input  ev_valid, ev_code, pressed, long_hold, overflow
  );
endinterface

// File: rtl/button_event_gen.sv
// Turns one debounced key level into PRESS / RELEASE / LONG / REPEAT events,
// delivered through a one-deep valid/ready buffer with a sticky drop flag.
module button_event_gen #(
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned HOLD_CYCLES   = 500000,
  parameter int unsigned REPEAT_CYCLES = 100000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  button_event_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DOWN   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  // Terminal counts: the counter is cleared on the compare edge, so it never wraps.
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               new_ev;
  logic [1:0]         new_code;

  logic               ev_valid_q, ev_valid_d;
  logic [1:0]         ev_code_q, ev_code_d;
  logic               overflow_q, overflow_d;
  logic               accept;

  logic               pressed_o, long_hold_o;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; release is checked first so it beats LONG/REPEAT on the same edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    new_ev   = 1'b0;
    new_code = EV_PRESS;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.level) begin
          state_d  = ST_DOWN;
          cnt_d    = '0;
          new_ev   = 1'b1;
          new_code = EV_PRESS;
        end
      end
      ST_DOWN: begin
        if (!bus.level) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          new_ev   = 1'b1;
          new_code = EV_RELEASE;
        end else if (cnt_q == HOLD_LAST) begin
          state_d  = ST_REPEAT;
          cnt_d    = '0;
          new_ev   = 1'b1;
          new_code = EV_LONG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!bus.level) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          new_ev   = 1'b1;
          new_code = EV_RELEASE;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          new_ev   = REPEAT_EN;
          new_code = EV_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Status outputs are pure decodes of the registered state
  always_comb begin
    pressed_o   = (state_q != ST_IDLE);
    long_hold_o = (state_q == ST_REPEAT);
  end

  assign accept = ev_valid_q & bus.ev_ready;

  // A new event may replace one being accepted on the same edge; otherwise it is dropped.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    overflow_d = overflow_q;
    if (new_ev) begin
      if (!ev_valid_q || accept) begin
        ev_valid_d = 1'b1;
        ev_code_d  = new_code;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      ev_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_code_q  <= EV_PRESS;
      overflow_q <= 1'b0;
    end else begin
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_code   = ev_code_q;
  assign bus.overflow  = overflow_q;
  assign bus.pressed   = pressed_o;
  assign bus.long_hold = long_hold_o;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: two instances (repeat on/off) with a
// scoreboard of expected event codes and delivery cycles per instance.
module tb_button_event_gen;

  localparam int unsigned CW  = 8;
  localparam int unsigned HC  = 8;
  localparam int unsigned RC  = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_err;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  button_event_gen_if ia();
  button_event_gen_if ib();

  button_event_gen #(.CNT_W(CW), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.master));

  button_event_gen #(.CNT_W(CW), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC), .REPEAT_EN(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input logic [1:0] code, input int c);
    exp_t e;
    e.code = code;
    e.cyc  = c;
    return e;
  endfunction

  // Scoreboards: each delivered event (valid & ready) must match the queue head.
  always @(negedge clk) begin
    if (ia.ev_valid && ia.ev_ready) begin
      if (qa.size() == 0) chk("A_unexpected_event", qa.size(), 1);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("A_code", int'(ia.ev_code), int'(e.code));
        chk("A_cycle", cyc, e.cyc);
      end
    end
    if (ib.ev_valid && ib.ev_ready) begin
      if (qb.size() == 0) chk("B_unexpected_event", qb.size(), 1);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("B_code", int'(ib.ev_code), int'(e.code));
        chk("B_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    n_checks = 0;
    n_err    = 0;
    rst = 1'b1;
    ia.level = 1'b1; ia.ev_ready = 1'b1;
    ib.level = 1'b0; ib.ev_ready = 1'b1;

    // 1. reset held with level high, then PRESS on the first free edge
    tick(3);
    chk("rst_valid", ia.ev_valid, 0);
    chk("rst_code", ia.ev_code, 0);
    chk("rst_pressed", ia.pressed, 0);
    chk("rst_long", ia.long_hold, 0);
    chk("rst_ovf", ia.overflow, 0);
    rst = 1'b0;
    qa.push_back(mk(2'b00, cyc + 1));
    tick();
    chk("s1_pressed", ia.pressed, 1);
    chk("s1_valid", ia.ev_valid, 1);
    ia.level = 1'b0;
    qa.push_back(mk(2'b01, cyc + 1));
    tick(3);
    chk("s1_released", ia.pressed, 0);

    // 2. short press: 4 high edges
    c = cyc;
    ia.level = 1'b1;
    qa.push_back(mk(2'b00, c + 1));
    tick(4);
    chk("s2_pressed", ia.pressed, 1);
    chk("s2_long", ia.long_hold, 0);
    ia.level = 1'b0;
    qa.push_back(mk(2'b01, c + 5));
    tick();
    chk("s2_idle", ia.pressed, 0);
    tick(3);

    // 3. long hold: 20 high edges, REPEAT due on release edge is suppressed
    c = cyc;
    ia.level = 1'b1;
    qa.push_back(mk(2'b00, c + 1));
    qa.push_back(mk(2'b10, c + 9));
    qa.push_back(mk(2'b11, c + 13));
    qa.push_back(mk(2'b11, c + 17));
    tick(8);
    chk("s3_long_before", ia.long_hold, 0);
    tick();
    chk("s3_long_at", ia.long_hold, 1);
    tick(11);
    chk("s3_long_hold", ia.long_hold, 1);
    ia.level = 1'b0;
    qa.push_back(mk(2'b01, c + 21));
    tick();
    chk("s3_long_end", ia.long_hold, 0);
    chk("s3_pressed_end", ia.pressed, 0);
    tick(3);

    // 4. backpressure: RELEASE dropped while PRESS is stuck
    ia.ev_ready = 1'b0;
    ia.level = 1'b1;
    tick(2);
    ia.level = 1'b0;
    tick();
    chk("s4_valid", ia.ev_valid, 1);
    chk("s4_code", ia.ev_code, 0);
    chk("s4_ovf", ia.overflow, 1);
    tick(2);
    chk("s4_code_hold", ia.ev_code, 0);
    ia.ev_ready = 1'b1;
    qa.push_back(mk(2'b00, cyc));
    tick();
    chk("s4_drained", ia.ev_valid, 0);
    chk("s4_ovf_sticky", ia.overflow, 1);
    tick(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s4_ovf_cleared", ia.overflow, 0);
    tick(2);

    // 5. accept and new event on the same edge
    c = cyc;
    ia.ev_ready = 1'b0;
    ia.level = 1'b1;
    tick(2);
    ia.level = 1'b0;
    ia.ev_ready = 1'b1;
    qa.push_back(mk(2'b00, c + 2));
    qa.push_back(mk(2'b01, c + 3));
    tick();
    chk("s5_valid", ia.ev_valid, 1);
    chk("s5_code", ia.ev_code, 1);
    chk("s5_ovf", ia.overflow, 0);
    tick(3);

    // 6. REPEAT_EN=0: PRESS, LONG, RELEASE only
    c = cyc;
    ib.level = 1'b1;
    qb.push_back(mk(2'b00, c + 1));
    qb.push_back(mk(2'b10, c + 9));
    tick(20);
    chk("s6_long_hold", ib.long_hold, 1);
    ib.level = 1'b0;
    qb.push_back(mk(2'b01, c + 21));
    tick();
    chk("s6_idle", ib.pressed, 0);
    tick(2);

    // reset while in REPEAT with LONG still pending
    c = cyc;
    ib.level = 1'b1;
    qb.push_back(mk(2'b00, c + 1));
    tick(8);
    ib.ev_ready = 1'b0;
    tick(3);
    chk("s6_pend_valid", ib.ev_valid, 1);
    chk("s6_pend_code", ib.ev_code, 2);
    chk("s6_pend_long", ib.long_hold, 1);
    rst = 1'b1;
    tick();
    chk("s6_rst_valid", ib.ev_valid, 0);
    chk("s6_rst_pressed", ib.pressed, 0);
    chk("s6_rst_long", ib.long_hold, 0);
    chk("s6_rst_ovf", ib.overflow, 0);
    chk("s6_rst_code", ib.ev_code, 0);
    rst = 1'b0;
    ib.ev_ready = 1'b1;
    qb.push_back(mk(2'b00, cyc + 1));
    tick();
    chk("s6_repress", ib.pressed, 1);
    ib.level = 1'b0;
    qb.push_back(mk(2'b01, cyc + 1));
    tick(4);

    chk("A_queue_empty", qa.size(), 0);
    chk("B_queue_empty", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
